// File: rtl/tdm_demux_16_pkg.sv
// Shared constants for the 16-channel TDM receive demultiplexer.
package tdm_demux_16_pkg;

  localparam int unsigned NCH  = 16;
  localparam int unsigned CH_W = 4;

  localparam logic [0:0] ST_HUNT   = 1'b0;
  localparam logic [0:0] ST_LOCKED = 1'b1;

endpackage

// File: rtl/tdm_demux_16_chan_counter.sv
// Channel slot counter: clear, load-to-1 (frame start), increment with natural wrap 15->0.
module tdm_chan_counter
  import tdm_demux_16_pkg::*;
(
  input  logic            clk,
  input  logic            rst_n,
  input  logic            clr,
  input  logic            load1,
  input  logic            inc,
  output logic [CH_W-1:0] cnt,
  output logic            wrap
);

  logic [CH_W-1:0] cnt_q;
  logic [CH_W-1:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr)        cnt_d = '0;
    else if (load1) cnt_d = CH_W'(1);
    else if (inc)   cnt_d = cnt_q + CH_W'(1);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) cnt_q <= '0;
    else        cnt_q <= cnt_d;
  end

  assign cnt  = cnt_q;
  assign wrap = (cnt_q == CH_W'(NCH - 1));

endmodule

// File: rtl/tdm_demux_16.sv
// 16:1 TDM demultiplexer: gathers one sample per valid beat into a shadow frame,
// publishes complete frames atomically and tracks frame-sync alignment.
module tdm_demux_16
  import tdm_demux_16_pkg::*;
#(
  parameter int unsigned DATA_W = 1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [DATA_W-1:0]     din,
  input  logic                  din_valid,
  input  logic                  frame_sync,
  output logic [NCH*DATA_W-1:0] dout,
  output logic                  frame_valid,
  output logic [CH_W-1:0]       ch_idx,
  output logic                  locked,
  output logic                  sync_err
);

  logic [0:0]            state_q, state_d;
  logic [NCH*DATA_W-1:0] shadow_q, shadow_d;
  logic [NCH*DATA_W-1:0] dout_q, dout_d;
  logic                  frame_valid_q, frame_valid_d;
  logic                  sync_err_q, sync_err_d;

  logic [CH_W-1:0] cnt;
  logic            cnt_wrap;
  logic            cnt_clr, cnt_load1, cnt_inc;
  logic            wr_en;

  tdm_chan_counter u_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (cnt_clr),
    .load1 (cnt_load1),
    .inc   (cnt_inc),
    .cnt   (cnt),
    .wrap  (cnt_wrap)
  );

  always_comb begin
    state_d       = state_q;
    dout_d        = dout_q;
    frame_valid_d = 1'b0;
    sync_err_d    = 1'b0;
    cnt_clr       = 1'b0;
    cnt_load1     = 1'b0;
    cnt_inc       = 1'b0;
    wr_en         = 1'b0;

    if (din_valid) begin
      if (state_q == ST_HUNT) begin
        if (frame_sync) begin
          cnt_load1 = 1'b1;
          state_d   = ST_LOCKED;
        end
      end else if (frame_sync) begin
        // Sync always restarts at channel 0; mid-frame it also abandons the partial frame.
        sync_err_d = (cnt != '0);
        cnt_load1  = 1'b1;
      end else if (cnt == '0) begin
        sync_err_d = 1'b1;
        cnt_clr    = 1'b1;
        state_d    = ST_HUNT;
      end else begin
        wr_en   = 1'b1;
        cnt_inc = 1'b1;
        if (cnt_wrap) begin
          dout_d        = {din, shadow_q[(NCH-1)*DATA_W-1:0]};
          frame_valid_d = 1'b1;
        end
      end
    end
  end

  // Slot 0 is written by any frame start; other slots only by in-sequence beats.
  always_comb begin
    shadow_d = shadow_q;
    for (int unsigned k = 0; k < NCH; k++) begin
      if ((cnt_load1 && k == 0) || (wr_en && cnt == CH_W'(k)))
        shadow_d[k*DATA_W +: DATA_W] = din;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= ST_HUNT;
      shadow_q      <= '0;
      dout_q        <= '0;
      frame_valid_q <= 1'b0;
      sync_err_q    <= 1'b0;
    end else begin
      state_q       <= state_d;
      shadow_q      <= shadow_d;
      dout_q        <= dout_d;
      frame_valid_q <= frame_valid_d;
      sync_err_q    <= sync_err_d;
    end
  end

  assign dout        = dout_q;
  assign frame_valid = frame_valid_q;
  assign ch_idx      = cnt;
  assign locked      = (state_q == ST_LOCKED);
  assign sync_err    = sync_err_q;

endmodule

// File: tb/tb_tdm_demux_16.sv
// Self-checking bench for tdm_demux_16 (DATA_W=1): behavioural frame model plus directed and random beats.
module tb_tdm_demux_16;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        din = 1'b0;
  logic        din_valid = 1'b0;
  logic        frame_sync = 1'b0;
  logic [15:0] dout;
  logic        frame_valid;
  logic [3:0]  ch_idx;
  logic        locked;
  logic        sync_err;

  int total = 0;
  int bad = 0;
  int fv_count = 0;
  int err_count = 0;

  // Behavioural model: lock flag, next-slot number, gathered samples, published frame.
  bit        m_locked = 0;
  int        m_idx = 0;
  bit [15:0] m_sh = '0;
  bit [15:0] m_dout = '0;
  bit        m_fv = 0;
  bit        m_err = 0;

  tdm_demux_16 #(.DATA_W(1)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .din         (din),
    .din_valid   (din_valid),
    .frame_sync  (frame_sync),
    .dout        (dout),
    .frame_valid (frame_valid),
    .ch_idx      (ch_idx),
    .locked      (locked),
    .sync_err    (sync_err)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  initial forever begin
    @(posedge clk or negedge rst_n);
    if (!rst_n) begin
      m_locked = 0; m_idx = 0; m_sh = '0; m_dout = '0; m_fv = 0; m_err = 0;
    end else begin
      m_fv = 0;
      m_err = 0;
      if (din_valid) begin
        if (!m_locked) begin
          if (frame_sync) begin
            m_sh[0] = din; m_idx = 1; m_locked = 1;
          end
        end else if (frame_sync) begin
          if (m_idx != 0) m_err = 1;
          m_sh[0] = din; m_idx = 1;
        end else if (m_idx == 0) begin
          m_err = 1; m_locked = 0;
        end else begin
          m_sh[m_idx] = din;
          if (m_idx == 15) begin
            m_dout = m_sh; m_fv = 1; m_idx = 0;
          end else begin
            m_idx++;
          end
        end
      end
    end
  end

  initial forever begin
    @(negedge clk);
    check("dout", 32'(dout), 32'(m_dout));
    check("frame_valid", 32'(frame_valid), 32'(m_fv));
    check("sync_err", 32'(sync_err), 32'(m_err));
    check("ch_idx", 32'(ch_idx), 32'(m_idx));
    check("locked", 32'(locked), 32'(m_locked));
    if (frame_valid === 1'b1) fv_count++;
    if (sync_err === 1'b1) err_count++;
  end

  task automatic beat(input logic v, input logic s, input logic d);
    @(negedge clk);
    din_valid = v; frame_sync = s; din = d;
  endtask

  task automatic send_frame(input logic [15:0] data);
    for (int i = 0; i < 16; i++) beat(1'b1, i == 0, data[i]);
  endtask

  logic [15:0] pat;
  logic [15:0] rnd;
  logic [15:0] cont_dout;
  int fv0, err0;

  initial begin
    #1;
    check("reset dout", 32'(dout), 32'h0);
    check("reset locked", 32'(locked), 32'h0);
    check("reset ch_idx", 32'(ch_idx), 32'h0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;

    // Directed frame: ch0..ch15 = 1,0,1,1,0,0,0,0,1,1,1,1,0,1,0,1
    pat = 16'hAF0D;
    send_frame(pat);
    beat(1'b0, 1'b0, 1'b0);
    check("first frame dout", 32'(dout), 32'hAF0D);
    check("first frame fv", 32'(frame_valid), 32'h1);
    check("first frame locked", 32'(locked), 32'h1);
    check("first frame fv count", 32'(fv_count), 32'd1);

    // Back-to-back all-ones then all-zeros
    err0 = err_count;
    send_frame(16'hFFFF);
    beat(1'b1, 1'b1, 1'b0);
    check("b2b frame1 dout", 32'(dout), 32'hFFFF);
    check("b2b frame1 fv", 32'(frame_valid), 32'h1);
    for (int i = 1; i < 16; i++) beat(1'b1, 1'b0, 1'b0);
    beat(1'b0, 1'b0, 1'b0);
    check("b2b frame2 dout", 32'(dout), 32'h0000);
    check("b2b frame2 fv", 32'(frame_valid), 32'h1);
    check("b2b no sync_err", 32'(err_count - err0), 32'd0);

    // Early sync on beat 5; that beat becomes ch0 of the new alignment
    fv0 = fv_count;
    for (int i = 0; i < 5; i++) beat(1'b1, i == 0, 1'b0);
    beat(1'b1, 1'b1, 1'b1);
    beat(1'b1, 1'b0, 1'b0);
    check("early sync_err", 32'(sync_err), 32'h1);
    check("early ch_idx", 32'(ch_idx), 32'd1);
    for (int i = 2; i < 16; i++) beat(1'b1, 1'b0, 1'(i % 3 == 0));
    beat(1'b0, 1'b0, 1'b0);
    check("early fv count", 32'(fv_count - fv0), 32'd1);
    check("early dout", 32'(dout), 32'h9249);

    // Missing sync at ch_idx 0, then 20 unsynced beats, then relock
    beat(1'b1, 1'b0, 1'b1);
    beat(1'b0, 1'b0, 1'b0);
    check("missing sync_err", 32'(sync_err), 32'h1);
    check("missing locked", 32'(locked), 32'h0);
    fv0 = fv_count;
    for (int i = 0; i < 20; i++) beat(1'b1, 1'b0, 1'($urandom_range(1)));
    beat(1'b0, 1'b0, 1'b0);
    check("hunt no fv", 32'(fv_count - fv0), 32'd0);
    check("hunt dout held", 32'(dout), 32'h9249);
    rnd = 16'($urandom);
    send_frame(rnd);
    beat(1'b0, 1'b0, 1'b0);
    check("relock locked", 32'(locked), 32'h1);
    check("relock dout", 32'(dout), 32'(rnd));
    cont_dout = dout;

    // Same data with din_valid toggling every cycle
    for (int i = 0; i < 16; i++) begin
      beat(1'b1, i == 0, rnd[i]);
      beat(1'b0, 1'b1, ~rnd[i]);
      check("toggle ch_idx hold", 32'(ch_idx), 32'((i + 1) % 16));
    end
    beat(1'b0, 1'b0, 1'b0);
    check("toggle dout", 32'(dout), 32'(cont_dout));

    // Asynchronous reset at ch_idx 9
    for (int i = 0; i < 9; i++) beat(1'b1, i == 0, 1'b1);
    beat(1'b0, 1'b0, 1'b0);
    check("pre-reset ch_idx", 32'(ch_idx), 32'd9);
    #2 rst_n = 1'b0;
    #1;
    check("async reset dout", 32'(dout), 32'h0);
    check("async reset ch_idx", 32'(ch_idx), 32'h0);
    check("async reset locked", 32'(locked), 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    send_frame(16'h5A3C);
    beat(1'b0, 1'b0, 1'b0);
    check("post-reset dout", 32'(dout), 32'h5A3C);

    // Random traffic: mostly aligned frames with sporadic gaps and stray syncs
    for (int n = 0; n < 3000; n++) begin
      logic v, s;
      v = ($urandom_range(3) != 0);
      s = (m_idx == 0) ? ($urandom_range(15) != 0) : ($urandom_range(40) == 0);
      beat(v, s, 1'($urandom_range(1)));
    end
    beat(1'b0, 1'b0, 1'b0);
    @(negedge clk);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/tdm_demux_16.md
Name: tdm_demux_16

Overview:
- Receive-side counterpart of the 16:1 channel mux.
- Takes a time-division-multiplexed sample stream (one channel per valid beat, channel 0 flagged by frame_sync) and routes each sample into its channel slot.
- Presents all 16 channels together as one frame, with a frame-valid strobe.
- Tracks frame alignment and flags sync errors. Sits directly after the serial/TDM link, ahead of per-channel consumers.

Parameters:
- DATA_W, 1, width in bits of one channel sample.
- NCH, 16, number of channels; fixed at 16 (4-bit index); not to be overridden.

Ports:
- clk  input  1  system clock; all state changes on its rising edge.
- rst_n  input  1  asynchronous active-low reset.
- din  input  DATA_W  sample for the current channel slot.
- din_valid  input  1  din is a valid sample this cycle.
- frame_sync  input  1  qualified by din_valid; marks the sample as channel 0.
- dout  output  16*DATA_W  last complete frame; channel k at dout[k*DATA_W +: DATA_W].
- frame_valid  output  1  one-cycle pulse when dout is updated.
- ch_idx  output  4  channel index the next valid sample will be written to.
- locked  output  1  high in LOCKED state.
- sync_err  output  1  one-cycle pulse on an alignment violation.

Behaviour:
- Reset (rst_n low, asynchronous):
  - state=HUNT, ch_idx=0, shadow buffer=0, dout=0.
  - frame_valid=0, sync_err=0, locked=0.
  - Reset mid-frame discards the partial frame; dout returns to 0.
- Cycles with din_valid=0: no state change; frame_sync is ignored.
- HUNT state:
  - Valid samples without frame_sync are dropped.
  - A valid sample with frame_sync is written to shadow[0]; ch_idx becomes 1; state goes to LOCKED.
- LOCKED state, on each valid sample:
  - ch_idx 1..15 with frame_sync=0: write shadow[ch_idx], then increment ch_idx.
  - ch_idx 1..15 with frame_sync=1 (early sync): sync_err pulses next cycle and the partial frame is discarded (no frame_valid). The sample is taken as channel 0: shadow[0]=din, ch_idx=1, state stays LOCKED.
  - ch_idx=0 with frame_sync=1: normal frame start; shadow[0]=din, ch_idx=1.
  - ch_idx=0 with frame_sync=0 (missing sync): sync_err pulses next cycle, the sample is dropped, state goes to HUNT, ch_idx=0.
- Frame completion (valid sample at ch_idx=15):
  - On the same edge: dout = {din, shadow[14:0]}, frame_valid=1 for exactly one cycle, ch_idx wraps to 0.
  - Latency: dout and frame_valid are visible the cycle after the channel-15 sample is presented.
- dout holds its value between frames. It is updated atomically, never partially.
- Back-to-back frames (din_valid held high) need no idle cycle. frame_valid may pulse every 16 cycles.
- Unused shadow contents are not cleared between frames. All 16 slots are rewritten before each dout update.
- locked = (state==LOCKED), registered.
- Outputs are glitch-free registered signals; no combinational path from inputs to outputs.

Decomposition:
- Shared package: NCH=16, CH_W=4, state encoding (HUNT=1'b0, LOCKED=1'b1).
- One natural sub-module: tdm_chan_counter (4-bit counter with load-to-1, clear, increment and wrap flag).
- Write-address decode and the shadow/output registers stay in the top level.

Test Plan (DATA_W=1):
- Reset, then 16 valid beats with sync on beat 0 and din pattern 1,0,1,1,0,0,0,0,1,1,1,1,0,1,0,1 (ch0..ch15) -> frame_valid pulses once, 1 cycle after beat 15; dout=16'hAF0D; locked=1.
- Two back-to-back frames with din=all-1 then all-0 -> frame_valid at cycles 16 and 32; dout=16'hFFFF then 16'h0000; sync_err never asserted.
- Sync asserted on beat 5 of a frame -> sync_err pulse; no frame_valid; next 15 beats complete the frame with that beat as ch0, and dout reflects the new alignment.
- Beat 16 (ch_idx=0) with no sync -> sync_err, locked=0, sample dropped; 20 unsynced beats produce no frame_valid; a later sync relocks.
- din_valid toggled 1/0 every cycle across a frame -> identical dout to the continuous case; ch_idx holds during invalid cycles.
- rst_n pulsed low asynchronously at ch_idx=9 -> dout=0, ch_idx=0, locked=0 immediately; the next synced frame is captured correctly.
